// File: rtl/rs_alu.sv
// Reservation station for the ALU. It holds issued instructions until both operands
// are known, snoops the ALU and LSB result buses, and dispatches one ready entry per cycle.
module rs_alu #(
    parameter int unsigned RS_SIZE  = 16,
    parameter int unsigned RS_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,

    input  logic        issue_en,
    input  logic [3:0]  issue_rob_pos,
    input  logic [6:0]  issue_opcode,
    input  logic [2:0]  issue_funct3,
    input  logic        issue_funct7,
    input  logic        issue_rs1_rdy,
    input  logic [31:0] issue_rs1_val,
    input  logic [3:0]  issue_rs1_tag,
    input  logic        issue_rs2_rdy,
    input  logic [31:0] issue_rs2_val,
    input  logic [3:0]  issue_rs2_tag,
    input  logic [31:0] issue_imm,
    input  logic [31:0] issue_pc,

    input  logic        alu_res,
    input  logic [3:0]  alu_res_rob_pos,
    input  logic [31:0] alu_res_val,
    input  logic        lsb_res,
    input  logic [3:0]  lsb_res_rob_pos,
    input  logic [31:0] lsb_res_val,

    output logic        rs_full,
    output logic        alu_en,
    output logic [3:0]  alu_rob_pos,
    output logic [6:0]  alu_opcode,
    output logic [2:0]  alu_funct3,
    output logic        alu_funct7,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_pc
);

    localparam int unsigned TAG_W = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;

    typedef struct packed {
        logic             rdy;
        logic [XLEN-1:0]  val;
        logic [TAG_W-1:0] tag;
    } opnd_t;

    typedef struct packed {
        logic             busy;
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  funct3;
        logic             funct7;
        logic [TAG_W-1:0] rob_pos;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        opnd_t            rs1;
        opnd_t            rs2;
    } entry_t;

    entry_t                ent_q [RS_SIZE];
    entry_t                ent_d [RS_SIZE];
    entry_t                new_ent;
    logic [RS_SIZE-1:0]    busy_vec;
    logic                  free_found;
    logic [RS_IDX_W-1:0]   free_idx;
    logic                  disp_found;
    logic [RS_IDX_W-1:0]   disp_idx;
    logic                  alloc;

    // Resolve a waiting operand against this cycle's broadcasts; ALU bus has priority.
    function automatic opnd_t snoop(input opnd_t op);
        opnd_t r;
        r = op;
        if (!op.rdy) begin
            if (alu_res && (alu_res_rob_pos == op.tag)) begin
                r.rdy = 1'b1;
                r.val = alu_res_val;
            end else if (lsb_res && (lsb_res_rob_pos == op.tag)) begin
                r.rdy = 1'b1;
                r.val = lsb_res_val;
            end
        end
        return r;
    endfunction

    // Lowest free slot and lowest eligible slot, both from start-of-cycle state.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        disp_found = 1'b0;
        disp_idx   = '0;
        busy_vec   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i] = ent_q[i].busy;
            if (!free_found && !ent_q[i].busy) begin
                free_found = 1'b1;
                free_idx   = RS_IDX_W'(i);
            end
            if (!disp_found && ent_q[i].busy && ent_q[i].rs1.rdy && ent_q[i].rs2.rdy) begin
                disp_found = 1'b1;
                disp_idx   = RS_IDX_W'(i);
            end
        end
    end

    assign rs_full = &busy_vec;
    assign alloc   = issue_en && !rs_full;

    // Incoming entry, with same-cycle broadcast forwarding applied.
    always_comb begin
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.opcode  = issue_opcode;
        new_ent.funct3  = issue_funct3;
        new_ent.funct7  = issue_funct7;
        new_ent.rob_pos = issue_rob_pos;
        new_ent.imm     = issue_imm;
        new_ent.pc      = issue_pc;
        new_ent.rs1     = snoop({issue_rs1_rdy, issue_rs1_val, issue_rs1_tag});
        new_ent.rs2     = snoop({issue_rs2_rdy, issue_rs2_val, issue_rs2_tag});
    end

    // Next entry state: wakeup, then free the dispatched slot, then allocate.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy) begin
                ent_d[i].rs1 = snoop(ent_q[i].rs1);
                ent_d[i].rs2 = snoop(ent_q[i].rs2);
            end
        end
        if (disp_found) begin
            ent_d[disp_idx].busy = 1'b0;
        end
        if (alloc) begin
            ent_d[free_idx] = new_ent;
        end
    end

    // Freed and allocated slots never coincide: the freed slot was busy at cycle start.
    always_ff @(posedge clk) begin
        if (rst || (rdy && rollback)) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            alu_en      <= 1'b0;
            alu_rob_pos <= '0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= ent_d[i];
            end
            alu_en <= disp_found;
            if (disp_found) begin
                alu_rob_pos <= ent_q[disp_idx].rob_pos;
                alu_opcode  <= ent_q[disp_idx].opcode;
                alu_funct3  <= ent_q[disp_idx].funct3;
                alu_funct7  <= ent_q[disp_idx].funct7;
                alu_val1    <= ent_q[disp_idx].rs1.val;
                alu_val2    <= ent_q[disp_idx].rs2.val;
                alu_imm     <= ent_q[disp_idx].imm;
                alu_pc      <= ent_q[disp_idx].pc;
            end
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: directed scenarios plus a short pseudo-random soak, checked every
// cycle against a behavioural reservation-station model.
module tb_rs_alu;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, issue_en;
    logic [3:0]  issue_rob_pos;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic        issue_funct7;
    logic        issue_rs1_rdy, issue_rs2_rdy;
    logic [31:0] issue_rs1_val, issue_rs2_val;
    logic [3:0]  issue_rs1_tag, issue_rs2_tag;
    logic [31:0] issue_imm, issue_pc;
    logic        alu_res, lsb_res;
    logic [3:0]  alu_res_rob_pos, lsb_res_rob_pos;
    logic [31:0] alu_res_val, lsb_res_val;
    logic        rs_full, alu_en;
    logic [3:0]  alu_rob_pos;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;

    always #5 clk = ~clk;

    rs_alu dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_en(issue_en), .issue_rob_pos(issue_rob_pos),
        .issue_opcode(issue_opcode), .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_rs1_rdy(issue_rs1_rdy), .issue_rs1_val(issue_rs1_val), .issue_rs1_tag(issue_rs1_tag),
        .issue_rs2_rdy(issue_rs2_rdy), .issue_rs2_val(issue_rs2_val), .issue_rs2_tag(issue_rs2_tag),
        .issue_imm(issue_imm), .issue_pc(issue_pc),
        .alu_res(alu_res), .alu_res_rob_pos(alu_res_rob_pos), .alu_res_val(alu_res_val),
        .lsb_res(lsb_res), .lsb_res_rob_pos(lsb_res_rob_pos), .lsb_res_val(lsb_res_val),
        .rs_full(rs_full), .alu_en(alu_en), .alu_rob_pos(alu_rob_pos),
        .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc)
    );

    typedef struct {
        bit          busy;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [3:0]  rob;
        logic [31:0] imm, pc;
        bit          r1, r2;
        logic [31:0] v1, v2;
        logic [3:0]  t1, t2;
    } ment_t;

    ment_t       m [16];
    logic        e_en;
    logic [3:0]  e_rob;
    logic [6:0]  e_opc;
    logic [2:0]  e_f3;
    logic        e_f7;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand value as seen after this cycle's broadcasts; ALU bus checked first.
    function automatic logic [32:0] resolve(input bit r, input logic [31:0] v, input logic [3:0] t);
        if (r) return {1'b1, v};
        if (alu_res && alu_res_rob_pos == t) return {1'b1, alu_res_val};
        if (lsb_res && lsb_res_rob_pos == t) return {1'b1, lsb_res_val};
        return {1'b0, v};
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int d = -1;
        int f = -1;
        logic [32:0] o;
        if (rst || (rdy && rollback)) begin
            foreach (m[i]) m[i].busy = 0;
            e_en = 0; e_rob = 0; e_opc = 0; e_f3 = 0; e_f7 = 0;
            e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0;
            return;
        end
        if (!rdy) return;
        foreach (m[i]) begin
            if (d < 0 && m[i].busy && m[i].r1 && m[i].r2) d = i;
            if (f < 0 && !m[i].busy) f = i;
        end
        e_en = (d >= 0);
        if (d >= 0) begin
            e_rob = m[d].rob; e_opc = m[d].opc; e_f3 = m[d].f3; e_f7 = m[d].f7;
            e_v1 = m[d].v1; e_v2 = m[d].v2; e_imm = m[d].imm; e_pc = m[d].pc;
        end
        foreach (m[i]) begin
            if (m[i].busy) begin
                o = resolve(m[i].r1, m[i].v1, m[i].t1); m[i].r1 = o[32]; m[i].v1 = o[31:0];
                o = resolve(m[i].r2, m[i].v2, m[i].t2); m[i].r2 = o[32]; m[i].v2 = o[31:0];
            end
        end
        if (d >= 0) m[d].busy = 0;
        if (issue_en && f >= 0) begin
            m[f].busy = 1; m[f].opc = issue_opcode; m[f].f3 = issue_funct3; m[f].f7 = issue_funct7;
            m[f].rob = issue_rob_pos; m[f].imm = issue_imm; m[f].pc = issue_pc;
            m[f].t1 = issue_rs1_tag; m[f].t2 = issue_rs2_tag;
            o = resolve(issue_rs1_rdy, issue_rs1_val, issue_rs1_tag); m[f].r1 = o[32]; m[f].v1 = o[31:0];
            o = resolve(issue_rs2_rdy, issue_rs2_val, issue_rs2_tag); m[f].r2 = o[32]; m[f].v2 = o[31:0];
        end
    endtask

    // One clock: update model, take the edge, compare every output.
    task automatic step();
        bit full;
        model_edge();
        @(posedge clk);
        #1;
        full = 1;
        foreach (m[i]) if (!m[i].busy) full = 0;
        chk("rs_full", rs_full, full);
        chk("alu_en", alu_en, e_en);
        chk("alu_rob_pos", alu_rob_pos, e_rob);
        chk("alu_opcode", alu_opcode, e_opc);
        chk("alu_funct3", alu_funct3, e_f3);
        chk("alu_funct7", alu_funct7, e_f7);
        chk("alu_val1", alu_val1, e_v1);
        chk("alu_val2", alu_val2, e_v2);
        chk("alu_imm", alu_imm, e_imm);
        chk("alu_pc", alu_pc, e_pc);
    endtask

    task automatic idle_inputs();
        issue_en = 0; alu_res = 0; lsb_res = 0; rollback = 0;
    endtask

    task automatic issue(input logic [3:0] rob, input logic [6:0] opc,
                         input bit r1, input logic [31:0] v1, input logic [3:0] t1,
                         input bit r2, input logic [31:0] v2, input logic [3:0] t2,
                         input logic [31:0] imm);
        issue_en = 1; issue_rob_pos = rob; issue_opcode = opc; issue_funct3 = 3'd0; issue_funct7 = 0;
        issue_rs1_rdy = r1; issue_rs1_val = v1; issue_rs1_tag = t1;
        issue_rs2_rdy = r2; issue_rs2_val = v2; issue_rs2_tag = t2;
        issue_imm = imm; issue_pc = 32'h1000 + {28'd0, rob};
    endtask

    initial begin
        rst = 1; rdy = 1; rollback = 0; issue_en = 0; alu_res = 0; lsb_res = 0;
        issue_rob_pos = 0; issue_opcode = 0; issue_funct3 = 0; issue_funct7 = 0;
        issue_rs1_rdy = 0; issue_rs1_val = 0; issue_rs1_tag = 0;
        issue_rs2_rdy = 0; issue_rs2_val = 0; issue_rs2_tag = 0;
        issue_imm = 0; issue_pc = 0;
        alu_res_rob_pos = 0; alu_res_val = 0; lsb_res_rob_pos = 0; lsb_res_val = 0;
        foreach (m[i]) m[i] = '{default: 0};
        step(); step();
        chk("reset_en", alu_en, 0);
        chk("reset_full", rs_full, 0);
        chk("reset_val1", alu_val1, 0);
        rst = 0;

        // ADDI, both operands ready: dispatch two edges after issue
        issue(4'd3, 7'b0010011, 1, 32'd5, 4'd0, 1, 32'd0, 4'd0, 32'd7);
        step();
        chk("addi_not_yet", alu_en, 0);
        idle_inputs();
        step();
        chk("addi_en", alu_en, 1);
        chk("addi_rob", alu_rob_pos, 3);
        chk("addi_val1", alu_val1, 5);
        chk("addi_imm", alu_imm, 7);
        step();
        chk("addi_one_cycle", alu_en, 0);

        // Wakeup from ALU broadcast
        issue(4'd4, 7'b0110011, 0, 32'd0, 4'd2, 1, 32'd1, 4'd0, 32'd0);
        step();
        idle_inputs();
        alu_res = 1; alu_res_rob_pos = 4'd2; alu_res_val = 32'h10;
        step();
        chk("wake_not_yet", alu_en, 0);
        idle_inputs();
        step();
        chk("wake_en", alu_en, 1);
        chk("wake_val1", alu_val1, 32'h10);

        // Forwarding of a same-cycle LSB broadcast into the allocated entry
        issue(4'd8, 7'b0110011, 1, 32'd9, 4'd0, 0, 32'd0, 4'd6, 32'd0);
        lsb_res = 1; lsb_res_rob_pos = 4'd6; lsb_res_val = 32'hABCD;
        step();
        idle_inputs();
        step();
        chk("fwd_en", alu_en, 1);
        chk("fwd_val2", alu_val2, 32'hABCD);
        step();

        // Fill all 16 slots, issue when full is ignored, free one and refill
        for (int i = 0; i < 16; i++) begin
            issue(4'(i), 7'b0110011, 0, 32'd0, 4'(i), 1, 32'd0, 4'd0, 32'd0);
            step();
        end
        chk("full_set", rs_full, 1);
        issue(4'd15, 7'b0010011, 1, 32'hEE, 4'd0, 1, 32'd0, 4'd0, 32'd0);
        step();
        chk("full_ignored", rs_full, 1);
        idle_inputs();
        step();
        chk("full_no_dispatch", alu_en, 0);
        alu_res = 1; alu_res_rob_pos = 4'd0; alu_res_val = 32'h77;
        step();
        idle_inputs();
        step();
        chk("full_free_en", alu_en, 1);
        chk("full_free_val1", alu_val1, 32'h77);
        chk("full_drops", rs_full, 0);
        issue(4'd12, 7'b0010011, 1, 32'h12, 4'd0, 1, 32'd0, 4'd0, 32'd0);
        step();
        chk("refill_full", rs_full, 1);
        idle_inputs();
        step();
        chk("refill_rob", alu_rob_pos, 12);
        rollback = 1;
        step();
        chk("rb_full", rs_full, 0);
        chk("rb_en", alu_en, 0);
        idle_inputs();

        // Slots 2 and 5 ready together, ALU bus beats LSB bus on the same tag
        for (int i = 0; i < 6; i++) begin
            issue(4'(i), 7'b0110011, 0, 32'd0, (i == 2 || i == 5) ? 4'hA : 4'hB, 1, 32'(i), 4'd0, 32'd0);
            step();
        end
        idle_inputs();
        alu_res = 1; alu_res_rob_pos = 4'hA; alu_res_val = 32'h55;
        lsb_res = 1; lsb_res_rob_pos = 4'hA; lsb_res_val = 32'h66;
        step();
        idle_inputs();
        step();
        chk("prio_first_rob", alu_rob_pos, 2);
        chk("prio_alu_wins", alu_val1, 32'h55);
        step();
        chk("prio_second_rob", alu_rob_pos, 5);
        chk("prio_second_en", alu_en, 1);
        step();
        chk("prio_done", alu_en, 0);
        rollback = 1;
        step();
        idle_inputs();

        // Rollback with three entries about to dispatch
        for (int i = 0; i < 3; i++) begin
            issue(4'(i + 1), 7'b0110011, 0, 32'd0, 4'hC, 1, 32'd3, 4'd0, 32'd0);
            step();
        end
        idle_inputs();
        alu_res = 1; alu_res_rob_pos = 4'hC; alu_res_val = 32'h99;
        step();
        idle_inputs();
        rollback = 1;
        step();
        chk("flush_en", alu_en, 0);
        chk("flush_full", rs_full, 0);
        chk("flush_val1", alu_val1, 0);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_no_stale", alu_en, 0);
        end

        // rdy low freezes everything, including a held alu_en
        issue(4'd1, 7'b0010011, 1, 32'h11, 4'd0, 1, 32'd0, 4'd0, 32'd0);
        step();
        issue(4'd2, 7'b0010011, 1, 32'h22, 4'd0, 1, 32'd0, 4'd0, 32'd0);
        step();
        rdy = 0;
        issue(4'd7, 7'b0010011, 1, 32'h77, 4'd0, 1, 32'd0, 4'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("freeze_en", alu_en, 1);
            chk("freeze_rob", alu_rob_pos, 1);
        end
        rdy = 1;
        idle_inputs();
        step();
        chk("thaw_rob", alu_rob_pos, 2);
        step();
        chk("thaw_idle", alu_en, 0);
        rdy = 0; rst = 1;
        step();
        chk("rst_rdy_low", alu_pc, 0);
        rdy = 1; rst = 0;

        // Pseudo-random soak
        for (int c = 0; c < 600; c++) begin
            issue_en = ($urandom_range(0, 1) == 1);
            issue(4'($urandom_range(0, 15)), 7'($urandom), $urandom_range(0, 1) == 1, $urandom,
                  4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, $urandom,
                  4'($urandom_range(0, 15)), $urandom);
            issue_en = ($urandom_range(0, 2) != 0);
            issue_funct3 = 3'($urandom);
            issue_funct7 = 1'($urandom);
            alu_res = ($urandom_range(0, 2) == 0);
            alu_res_rob_pos = 4'($urandom); alu_res_val = $urandom;
            lsb_res = ($urandom_range(0, 2) == 0);
            lsb_res_rob_pos = 4'($urandom); lsb_res_val = $urandom;
            rdy = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_alu.md
RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 Parameter RS_SIZE, default 16, number of reservation-station entries.
REQ-002 Parameter RS_IDX_W, default 4, entry index width; log2(RS_SIZE).
REQ-003 clk input 1: clock; all state updates on posedge.
REQ-004 rst input 1: reset, synchronous, active-high.
REQ-005 rdy input 1: global enable; low freezes all state and outputs.
REQ-006 rollback input 1: mispredict flush.
REQ-007 issue_en input 1: allocate one entry this cycle.
REQ-008 issue_rob_pos input 4: destination ROB tag.
REQ-009 issue_opcode input 7, issue_funct3 input 3, issue_funct7 input 1: decoded instruction fields.
REQ-010 issue_rs1_rdy / issue_rs2_rdy input 1: operand value is valid.
REQ-011 issue_rs1_val / issue_rs2_val input 32: operand value when ready.
REQ-012 issue_rs1_tag / issue_rs2_tag input 4: producing ROB tag when not ready.
REQ-013 issue_imm input 32, issue_pc input 32: immediate and instruction PC.
REQ-014 alu_res input 1, alu_res_rob_pos input 4, alu_res_val input 32: ALU broadcast.
REQ-015 lsb_res input 1, lsb_res_rob_pos input 4, lsb_res_val input 32: load/store broadcast.
REQ-016 rs_full output 1: every entry busy.
REQ-017 alu_en output 1: one-cycle dispatch strobe to ALU.
REQ-018 alu_rob_pos 4, alu_opcode 7, alu_funct3 3, alu_funct7 1, alu_val1 32, alu_val2 32, alu_imm 32, alu_pc 32: registered dispatch payload, valid with alu_en.

Function
REQ-019 Each entry holds busy, opcode, funct3, funct7, rob_pos, imm, pc, and per operand {rdy, val, tag}.
REQ-020 Allocation: issue_en with rs_full low writes the lowest-index non-busy entry (per start-of-cycle state); busy set next edge.
REQ-021 issue_en while rs_full high: ignored, no state change.
REQ-022 Allocation forwarding: a non-ready issued operand whose tag matches a same-cycle valid alu_res or lsb_res broadcast is stored ready with the broadcast value.
REQ-023 Wakeup: each busy entry, non-ready operand with tag equal to a valid broadcast rob_pos, captures the value and sets rdy at the edge; alu broadcast wins if both match with the same tag.
REQ-024 Entry is eligible when busy and both operand rdy bits set, judged on start-of-cycle state (wakeup at edge N -> eligible from cycle N+1).
REQ-025 Dispatch: at most one entry per cycle, lowest-index eligible; at the edge its payload loads into alu_* registers, alu_en=1, entry busy cleared.
REQ-026 No eligible entry: alu_en=0 at edge; payload registers hold prior values.
REQ-027 alu_val2 carries rs2 value unconditionally; ALU chooses val2/imm.
REQ-028 Minimum latency issue -> alu_en: 2 edges (allocate, then dispatch) with both operands ready at issue.
REQ-029 Same-cycle dispatch and allocation: allocation cannot reuse the entry being freed.
REQ-030 rs_full is combinational from registered busy bits; a dispatch frees space visible next cycle.
REQ-031 Occupancy never exceeds RS_SIZE; no entry lost or duplicated under any issue/dispatch/wakeup combination.
REQ-032 rdy low: no allocation, wakeup, dispatch; outputs hold.

Reset
REQ-033 rst (when rdy either level) or rollback at edge: all busy cleared, alu_en=0, all alu_* payload outputs 0; pending issue/broadcast that cycle discarded.
REQ-034 rs_full=0 in cycle after reset/rollback.
REQ-035 rst has priority over all other inputs.

Verification
REQ-036 Issue ADDI rob 3, rs1 ready val 5, imm 7 -> 2 edges later alu_en=1, rob_pos 3, val1 5, imm 7, for one cycle.
REQ-037 Issue ADD rob 4, rs1 tag 2 not ready; next cycle alu_res rob 2 val 0x10 -> alu_en follows one cycle after wakeup edge, val1 0x10.
REQ-038 Issue with rs2 tag 6 while lsb_res rob 6 val 0xABCD same cycle -> entry stored ready, dispatched with val2 0xABCD.
REQ-039 Fill 16 not-ready entries -> rs_full=1, 17th issue ignored; wake entry 0 -> dispatched, rs_full drops following cycle, refill succeeds.
REQ-040 Two entries ready simultaneously at indices 5 and 2 -> index 2 dispatched first, index 5 next cycle.
REQ-041 rollback with 3 busy entries and pending dispatch -> alu_en=0 next cycle, rs_full=0, no stale dispatch thereafter.
